// File: rtl/fp_norm_pkg.sv
// Shared types and helpers for the FP adder normalisation stage.
package fp_norm_pkg;

    localparam int FRAC_W_DEF = 23;
    localparam int LZC_W      = $clog2(FRAC_W_DEF + 2);

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } fp_status_t;

    function automatic int unsigned exp_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned lzc_w(input int unsigned frac_w);
        return $clog2(frac_w + 2);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; count is W when the input is all zero.
module fp_lzc #(
    parameter int W  = 24,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt,
    output logic          all_zero
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        cnt      = CW'(W);
        all_zero = (din == '0);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_normalise_pipe.sv
// Two-stage significand normaliser with zero/overflow/subnormal flags
// and a valid/ready handshake that sustains one beat per cycle.
module fp_normalise_pipe
    import fp_norm_pkg::*;
#(
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W+1:0] in_frac,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W:0]   out_frac,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam int SW = int'(lzc_w(FRAC_W));
    localparam logic [EXP_W:0] EXP_ALL = (EXP_W + 1)'(exp_max(EXP_W));

    logic              s1_valid_q, s1_valid_d;
    logic [FRAC_W+1:0] s1_frac_q, s1_frac_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic              s1_op_q, s1_op_d;
    logic [SW-1:0]     s1_cnt_q, s1_cnt_d;
    logic              s1_carry_q, s1_carry_d;
    logic              s1_zero_q, s1_zero_d;

    logic              s2_valid_q, s2_valid_d;
    logic [FRAC_W:0]   s2_frac_q, s2_frac_d;
    logic [EXP_W-1:0]  s2_exp_q, s2_exp_d;
    fp_status_t        s2_st_q, s2_st_d;

    logic              s1_load, s2_load;
    logic [SW-1:0]     lzc_cnt;
    logic              lzc_zero;

    logic [FRAC_W:0]   n_frac;
    logic [EXP_W-1:0]  n_exp;
    fp_status_t        n_st;
    logic [EXP_W:0]    e_wide, e_inc, e_sub, cnt_wide, sub_sh;

    fp_lzc #(
        .W  (FRAC_W + 1),
        .CW (SW)
    ) u_lzc (
        .din      (in_frac[FRAC_W:0]),
        .cnt      (lzc_cnt),
        .all_zero (lzc_zero)
    );

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_frac_d  = s1_frac_q;
        s1_exp_d   = s1_exp_q;
        s1_op_d    = s1_op_q;
        s1_cnt_d   = s1_cnt_q;
        s1_carry_d = s1_carry_q;
        s1_zero_d  = s1_zero_q;
        if (s1_load) s1_valid_d = in_valid;
        if (s1_load && in_valid) begin
            s1_frac_d  = in_frac;
            s1_exp_d   = in_exp;
            s1_op_d    = in_op;
            s1_cnt_d   = lzc_cnt;
            s1_carry_d = in_frac[FRAC_W+1];
            s1_zero_d  = lzc_zero && !in_frac[FRAC_W+1];
        end
    end

    // Exponent maths is one bit wider so carry and borrow are visible.
    always_comb begin
        e_wide   = {1'b0, s1_exp_q};
        e_inc    = e_wide + (EXP_W + 1)'(1);
        cnt_wide = (EXP_W + 1)'(s1_cnt_q);
        e_sub    = e_wide - cnt_wide;
        sub_sh   = (e_wide == '0) ? '0 : e_wide - (EXP_W + 1)'(1);
        n_frac   = '0;
        n_exp    = '0;
        n_st     = '0;
        if (s1_zero_q) begin
            n_st.zero = 1'b1;
        end else if (s1_carry_q) begin
            if (e_inc >= EXP_ALL) begin
                n_st.ovf = 1'b1;
                n_exp    = EXP_ALL[EXP_W-1:0];
            end else begin
                n_frac = s1_frac_q[FRAC_W+1:1];
                n_exp  = e_inc[EXP_W-1:0];
            end
        end else if (s1_frac_q[FRAC_W]) begin
            n_frac = s1_frac_q[FRAC_W:0];
            n_exp  = s1_exp_q;
        end else if (cnt_wide < e_wide) begin
            n_frac = s1_frac_q[FRAC_W:0] << s1_cnt_q;
            n_exp  = e_sub[EXP_W-1:0];
        end else begin
            n_st.unf = 1'b1;
            n_frac   = s1_frac_q[FRAC_W:0] << sub_sh[SW-1:0];
        end
    end

    always_comb begin
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_frac_d  = s2_frac_q;
        s2_exp_d   = s2_exp_q;
        s2_st_d    = s2_st_q;
        if (s2_load && s1_valid_q) begin
            s2_frac_d = n_frac;
            s2_exp_d  = n_exp;
            s2_st_d   = n_st;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_frac_q  <= '0;
            s1_exp_q   <= '0;
            s1_op_q    <= 1'b0;
            s1_cnt_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_frac_q  <= '0;
            s2_exp_q   <= '0;
            s2_st_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_frac_q  <= s1_frac_d;
            s1_exp_q   <= s1_exp_d;
            s1_op_q    <= s1_op_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_carry_q <= s1_carry_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            s2_frac_q  <= s2_frac_d;
            s2_exp_q   <= s2_exp_d;
            s2_st_q    <= s2_st_d;
        end
    end

    // A subtraction can never produce a carry out of the significand.
    ast_no_sub_carry: assert property (@(posedge clk) disable iff (rst)
        s1_valid_q |-> !(s1_op_q && s1_carry_q));

    assign out_valid = s2_valid_q;
    assign out_frac  = s2_frac_q;
    assign out_exp   = s2_exp_q;
    assign out_zero  = s2_st_q.zero;
    assign out_ovf   = s2_st_q.ovf;
    assign out_unf   = s2_st_q.unf;

endmodule

// File: doc/fp_normalise_pipe.md
# fp_normalise_pipe

Pipelined, parametrised normalisation stage for the floating-point adder datapath. It sits between the big ALU and the rounding/packing stage. It takes the raw significand sum or difference and its provisional exponent, and returns a normalised significand with the hidden bit at position FRAC_W. It also reports zero, exponent overflow and exponent underflow (subnormal) results. A valid/ready handshake sustains one result per cycle with backpressure.

## Interface
- FRAC_W, default 23: stored fraction width; the significand including the hidden bit is FRAC_W+1 bits.
- EXP_W, default 8: biased exponent width.
- clk, input, 1: the only clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: input beat present.
- in_ready, output, 1: stage can accept a beat this cycle.
- in_frac, input, FRAC_W+2: ALU result; bit FRAC_W+1 is the carry, bit FRAC_W is the hidden-bit position.
- in_exp, input, EXP_W: provisional biased exponent, which is the larger operand's exponent.
- in_op, input, 1: 0 = addition, 1 = subtraction.
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts the result.
- out_frac, output, FRAC_W+1: normalised significand with the hidden bit.
- out_exp, output, EXP_W: adjusted exponent.
- out_zero, output, 1: result is exact zero.
- out_ovf, output, 1: exponent overflow; the result is infinity.
- out_unf, output, 1: result is subnormal.

## Operation
- The normalisation rule is the same for both in_op values; in_op is carried to stage 1 only for debug and assertions.
- **Carry set** (in_frac[FRAC_W+1] = 1):
  - Shift right by 1 and set exp = in_exp + 1.
  - If in_exp + 1 equals all-ones: out_ovf = 1, out_exp = all-ones, out_frac = 0.
- **Carry clear, hidden bit set:** pass the value through with shift 0. An already-normalised difference must never pick up a stale shift.
- **Carry clear, hidden bit clear:**
  - shamt = FRAC_W − (index of the leading one in in_frac[FRAC_W:0]).
  - If shamt < in_exp: shift left by shamt and set exp = in_exp − shamt.
  - Otherwise the result is subnormal: out_unf = 1, out_exp = 0, shift left by max(in_exp − 1, 0).
- **in_frac all zero:** out_zero = 1, out_exp = 0, out_frac = 0; out_ovf and out_unf are 0.
- **Assertion:** in_op = 1 with the carry set is illegal (assertion only). The datapath still applies the carry-set rule in that case.
- **Width rules:**
  - Compute exponent arithmetic in EXP_W+1 bits so borrow and carry can be detected.
  - The shift count is $clog2(FRAC_W+2) bits wide.

## Timing
- Two register stages:
  - Stage 1 registers the leading-zero count, the carry flag, the zero flag and the input fields.
  - Stage 2 registers the shifted significand, exponent and flags.
- Latency is 2 cycles from an accepted input beat to out_valid, with out_ready held high.
- Throughput is 1 beat per cycle.
- Stall logic:
  - Stage 2 loads when it is empty or out_ready = 1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = stage-1 empty OR stage 2 loads. This path is combinational from out_ready.
- A beat transfers when valid && ready are both high.
- out_* are held stable while out_valid = 1 and out_ready = 0.
- Reset clears both valid bits and all data registers to 0. out_valid = 0, all flags 0, out_frac = 0, out_exp = 0.
- Assertion of rst mid-flight discards in-flight beats.
- in_ready is 1 from the first cycle after rst deasserts.

## Structure
- Package fp_norm_pkg holds:
  - LZC_W = $clog2(FRAC_W+2).
  - exp_max(EXP_W), the all-ones helper.
  - A packed status struct {zero, ovf, unf} shared with the rounding stage.
- Sub-module fp_lzc: a parametrised leading-zero counter over FRAC_W+1 bits. It outputs a count and an all-zero flag, and is instanced in stage 1.

## Test plan
- **Addition carry:** in_frac = 0x1800000, in_exp = 0x80, op = 0 → out_frac = 0xC00000, out_exp = 0x81, no flags, 2 cycles later.
- **Large cancellation:** in_frac = 0x0000001, in_exp = 0x80, op = 1 → out_frac = 0x800000, out_exp = 0x69. Then in_frac = 0x0800000 → shift 0, exp unchanged.
- **Zero and underflow:**
  - in_frac = 0 → out_zero = 1, out_exp = 0.
  - in_frac = 0x0000100, in_exp = 5 → out_unf = 1, out_exp = 0, out_frac = 0x001000.
- **Overflow:** in_frac = 0x1000000, in_exp = 0xFE, op = 0 → out_ovf = 1, out_exp = 0xFF, out_frac = 0.
- **Backpressure:** stream 5 back-to-back beats with out_ready low for 3 cycles → in_ready falls after 2 beats are held, outputs stay stable, all 5 results arrive in order with none lost or duplicated.
- **Reset mid-flight:** assert rst with both stages valid → out_valid = 0 immediately (async), no stale beat emitted after release.
